// File: rtl/sap_pkg.sv
// Shared definitions for the SAP data-path blocks: source tags, merge
// state encoding and the default word width.
package sap_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic SRC_0 = 1'b0;
  localparam logic SRC_1 = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } merge_state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter. A tie goes to the requester that did
// not win last; the history only moves on an advance strobe.
module rr_arbiter_2
  import sap_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_grant_reg;
  logic last_grant_next;

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant_reg == SRC_1) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_comb begin
    last_grant_next = last_grant_reg;
    if (advance) begin
      last_grant_next = grant[1] ? SRC_1 : SRC_0;
    end
  end

  // Reset to SRC_1 so source 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= SRC_1;
    end else begin
      last_grant_reg <= last_grant_next;
    end
  end

endmodule

// File: rtl/bus_merge_2line_8bit.sv
// Two-source, one-sink merge with round-robin arbitration and a single
// registered output word tagged with its source.
module bus_merge_2line_8bit
  import sap_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  output logic             out_valid,
  input  logic             out_ready
);

  merge_state_t     state_reg;
  merge_state_t     state_next;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] data_next;
  logic             src_reg;
  logic             src_next;

  logic       can_load;
  logic [1:0] grant;
  logic [1:0] ready_vec;
  logic       load;

  // The output slot may be refilled in the same cycle it is consumed.
  assign can_load = (state_reg == ST_EMPTY) | out_ready;

  rr_arbiter_2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({in1_valid, in0_valid}),
    .advance (load),
    .grant   (grant)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign ready_vec[gi] = can_load & grant[gi] & ~rst;
    end
  endgenerate

  assign in0_ready = ready_vec[0];
  assign in1_ready = ready_vec[1];
  assign load      = |ready_vec;

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    src_next   = src_reg;
    unique case (state_reg)
      ST_EMPTY: begin
        if (load) state_next = ST_FULL;
      end
      ST_FULL: begin
        if (out_ready && !load) state_next = ST_EMPTY;
      end
      default: state_next = ST_EMPTY;
    endcase
    // Data and tag only change on a load; a plain consume leaves them as-is.
    if (load) begin
      data_next = grant[1] ? in1_data : in0_data;
      src_next  = grant[1] ? SRC_1 : SRC_0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_EMPTY;
      data_reg  <= '0;
      src_reg   <= SRC_0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      src_reg   <= src_next;
    end
  end

  assign out_valid = (state_reg == ST_FULL);
  assign out_data  = data_reg;
  assign out_src   = src_reg;

endmodule

// File: tb/tb_bus_merge_2line_8bit.sv
// Self-checking bench for bus_merge_2line_8bit: directed test-plan steps
// followed by random traffic, all checked against a transaction-level model.
module tb_bus_merge_2line_8bit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in0_data, in1_data, out_data;
  logic       in0_valid, in1_valid, in0_ready, in1_ready;
  logic       out_src, out_valid, out_ready;

  int checks = 0;
  int errors = 0;

  // Reference model: the contents of the single output slot plus who won last.
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_src;
  logic       m_last;

  always #5 clk = ~clk;

  bus_merge_2line_8bit #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_data  (in0_data),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in1_data  (in1_data),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_src   = 1'b0;
    m_last  = 1'b1;
  endtask

  // One clock cycle: drive inputs, check readies and outputs, advance model.
  task automatic step(input logic r, input logic v0, input logic [7:0] d0,
                      input logic v1, input logic [7:0] d1, input logic ordy);
    logic e0, e1, room;
    @(negedge clk);
    rst = r; in0_valid = v0; in0_data = d0;
    in1_valid = v1; in1_data = d1; out_ready = ordy;
    #1;
    room = !m_valid || ordy;
    e0 = 1'b0;
    e1 = 1'b0;
    if (!r && room) begin
      if (v0 && v1) begin
        if (m_last) e0 = 1'b1; else e1 = 1'b1;
      end else begin
        e0 = v0;
        e1 = v1;
      end
    end
    chk("in0_ready", {7'd0, in0_ready}, {7'd0, e0});
    chk("in1_ready", {7'd0, in1_ready}, {7'd0, e1});
    chk("out_valid", {7'd0, out_valid}, {7'd0, m_valid});
    chk("out_data",  out_data, m_data);
    chk("out_src",   {7'd0, out_src}, {7'd0, m_src});
    @(posedge clk);
    if (r) begin
      $display("t=%0t reset", $time);
      model_reset();
    end else begin
      if (m_valid && ordy)
        $display("t=%0t consume data=%h src=%0d", $time, m_data, m_src);
      if (e0 || e1) begin
        m_data  = e1 ? d1 : d0;
        m_src   = e1;
        m_last  = e1;
        m_valid = 1'b1;
        $display("t=%0t accept  data=%h src=%0d", $time, m_data, m_src);
      end else if (m_valid && ordy) begin
        m_valid = 1'b0;
      end
    end
  endtask

  // Direct check of the output slot against test-plan constants, just after an edge.
  task automatic expect_out(input string tag, input logic v, input logic [7:0] d, input logic s);
    #1;
    chk({tag, "_valid"}, {7'd0, out_valid}, {7'd0, v});
    chk({tag, "_data"},  out_data, d);
    chk({tag, "_src"},   {7'd0, out_src}, {7'd0, s});
  endtask

  initial begin
    rst = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0;
    in0_data = 8'h00; in1_data = 8'h00; out_ready = 1'b0;
    model_reset();
    @(posedge clk);

    // Reset held with both sources offering words.
    step(1, 1, 8'h11, 1, 8'h22, 1);
    step(1, 1, 8'h11, 1, 8'h22, 1);
    expect_out("reset", 0, 8'h00, 0);
    step(0, 1, 8'h11, 1, 8'h22, 1);
    expect_out("first_tie", 1, 8'h11, 0);

    // Single source.
    step(1, 0, 8'h00, 0, 8'h00, 1);
    step(0, 1, 8'h3C, 0, 8'h00, 1);
    expect_out("single", 1, 8'h3C, 0);
    step(0, 0, 8'h00, 0, 8'h00, 1);

    // Round-robin with both sources always valid.
    step(1, 0, 8'h00, 0, 8'h00, 1);
    step(0, 1, 8'hA1, 1, 8'hB2, 1);
    expect_out("rr0", 1, 8'hA1, 0);
    step(0, 1, 8'hA2, 1, 8'hB2, 1);
    expect_out("rr1", 1, 8'hB2, 1);
    step(0, 1, 8'hA2, 1, 8'hB3, 1);
    expect_out("rr2", 1, 8'hA2, 0);
    step(0, 1, 8'hA3, 1, 8'hB3, 1);
    expect_out("rr3", 1, 8'hB3, 1);

    // Backpressure then consume-and-load on the same edge.
    step(0, 0, 8'h00, 1, 8'h55, 1);
    expect_out("bp_load", 1, 8'h55, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 8'hC3, 0, 8'h00, 0);
      expect_out("bp_hold", 1, 8'h55, 1);
    end
    step(0, 1, 8'hC3, 0, 8'h00, 1);
    expect_out("bp_release", 1, 8'hC3, 0);

    // Drain with no sources.
    step(0, 1, 8'h7E, 0, 8'h00, 1);
    expect_out("drain_load", 1, 8'h7E, 0);
    step(0, 0, 8'h00, 0, 8'h00, 1);
    expect_out("drain", 0, 8'h7E, 0);
    step(0, 0, 8'h00, 0, 8'h00, 1);

    // Reset while a stalled word is held.
    step(0, 0, 8'h00, 1, 8'h99, 1);
    step(0, 0, 8'h00, 0, 8'h00, 0);
    expect_out("mid_full", 1, 8'h99, 1);
    step(1, 1, 8'hAA, 1, 8'hBB, 0);
    expect_out("mid_reset", 0, 8'h00, 0);
    step(0, 0, 8'h00, 0, 8'h00, 1);
    expect_out("mid_after", 0, 8'h00, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0),
           1'($urandom_range(0, 1)), 8'($urandom),
           1'($urandom_range(0, 1)), 8'($urandom),
           ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_merge_2line_8bit.md
Name: bus_merge_2line_8bit

Overview:
- Two-source, one-sink merge for the 8-bit SAP data path; the sending-side counterpart to the 1-to-2 bus demux.
- Two producers (e.g. ALU result and RAM read) each offer a word with a valid/ready handshake.
- The block arbitrates between them round-robin and presents one registered word per transfer on a single output channel, tagged with its source.
- It sits between the producers and the shared bus/register-load logic.

Parameters:
- WIDTH, 8, data width of each input and of the output word.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in0_data  input  WIDTH  word from source 0.
- in0_valid  input  1  source 0 offers in0_data.
- in0_ready  output  1  block accepts in0_data this cycle.
- in1_data  input  WIDTH  word from source 1.
- in1_valid  input  1  source 1 offers in1_data.
- in1_ready  output  1  block accepts in1_data this cycle.
- out_data  output  WIDTH  registered merged word.
- out_src  output  1  source of out_data (0 or 1).
- out_valid  output  1  out_data/out_src hold a word.
- out_ready  input  1  sink consumes the word this cycle.

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: out_valid=0, out_data=0, out_src=0, last_grant=1, so source 0 wins the first tie. Reset mid-transfer discards the held word; no handshake completes in the reset cycle, and in0_ready=in1_ready=0 while rst=1.
- Handshakes: a transfer occurs on an edge where valid&ready are both 1 on that channel. Sources must hold data and valid stable until accepted; the block must not assume they do beyond that.
- FSM states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- can_load = ~out_valid | out_ready. This is combinational: a word may be replaced in the same cycle it is consumed, giving full throughput of 1 word/cycle.
- Grant logic (combinational):
  - Only in0_valid -> grant 0.
  - Only in1_valid -> grant 1.
  - Both valid -> grant the source != last_grant.
  - Neither -> no grant.
- Ready outputs: inN_ready = can_load & grantN & ~rst. At most one ready is high in any cycle.
- On an accepted transfer:
  - out_data <= inN_data; out_src <= N; out_valid <= 1; last_grant <= N.
- Consume without a new load (out_valid & out_ready & no grant): out_valid <= 0. out_data and out_src keep their last value.
- FULL with out_ready=0: outputs are frozen and both in*_ready=0 (backpressure).
- Simultaneous consume + load: the new word replaces the old one in a single edge, and out_valid stays 1.
- Latency: 1 cycle from acceptance to out_valid.
- No combinational path from inN_data to out_data. The only combinational paths to ready are from the valids, out_ready and internal state.
- Fairness: with both sources continuously valid and out_ready=1, grants alternate 0,1,0,1...
- Starvation bound: a waiting source is served within 2 accepted transfers.

Decomposition:
- Shared package (sap_pkg):
  - constants SRC_0=1'b0 and SRC_1=1'b1;
  - state encoding ST_EMPTY/ST_FULL;
  - default WIDTH=8.
- Natural sub-module: rr_arbiter_2, a 2-requester round-robin arbiter. It takes req[1:0] and an advance strobe, outputs a one-hot grant, and holds the last_grant register.
- The merge top instantiates rr_arbiter_2 and holds the output register plus the EMPTY/FULL state.

Test Plan:
- Reset: assert rst for 2 cycles with both valids high -> out_valid=0, out_data=0x00, in0_ready=in1_ready=0. After release, first edge accepts source 0.
- Single source: in0_valid=1, in0_data=0x3C, out_ready=1 -> next cycle out_valid=1, out_data=0x3C, out_src=0. Hold off in1 -> in1_ready never 1.
- Tie / round-robin: both valid, in0=0xA1, in1=0xB2, out_ready=1 for 4 cycles, both sources incrementing on acceptance -> outputs 0xA1/src0, 0xB2/src1, 0xA2/src0, 0xB3/src1.
- Backpressure: load 0x55 from source 1, then out_ready=0 for 3 cycles with in0_valid=1 -> out_data stays 0x55, out_src stays 1, in0_ready=0. On out_ready=1, 0x55 is consumed and the in0 word is loaded in the same edge.
- Drain: FULL with 0x7E, out_ready=1, no valids -> next cycle out_valid=0 and no ready pulses.
- Reset mid-operation: FULL with 0x99 and out_ready=0, assert rst one cycle -> out_valid=0, out_data=0x00, and the 0x99 word is never observed consumed.
